// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter in front of a single-ported data memory.
//   Port 0 : pipeline MEM-stage requester, normally has priority.
//   Port 1 : loader/debug requester, served when port 0 is idle or once
//            port 0 has been granted STARVE_LIMIT times in a row while
//            port 1 was waiting.
//
// Ports
//   clk, rst                       clock, asynchronous active-low reset
//   p0_req/we/addr/wdata/func3     port-0 request (func3 = RISC-V width code)
//   p0_gnt, p0_stall               port-0 grant and pipeline hold
//   p0_rvalid, p0_rdata            port-0 load return (one cycle after grant)
//   p1_req/we/addr/wdata/func3     port-1 request
//   p1_gnt, p1_rvalid, p1_rdata    port-1 grant and load return
//   m_addr, m_wdata, m_byte_sel    memory address, store data, width
//   m_r_en, m_w_en                 memory read / write enables
//   m_rdata                        raw memory word, valid cycle after m_r_en
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [2:0]  p0_func3,
    output logic        p0_gnt,
    output logic        p0_stall,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [2:0]  p1_func3,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,

    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_r_en,
    output logic        m_w_en,
    output logic [1:0]  m_byte_sel,
    input  logic [31:0] m_rdata
);

    // Counter is at least 3 bits and always wide enough to hold STARVE_LIMIT.
    localparam int CW = (STARVE_LIMIT < 8) ? 3 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        OWNER_P0 = 1'b0,
        OWNER_P1 = 1'b1
    } owner_t;

    logic [CW-1:0] r_starve_cnt;
    logic          r_pend_valid;
    owner_t        r_pend_owner;
    logic [2:0]    r_pend_func3;

    logic [CW-1:0] w_starve_nxt;
    logic          w_starved;
    logic          w_p0_win;
    logic          w_p1_win;
    logic          w_any_gnt;
    logic          w_sel_we;
    logic [2:0]    w_sel_func3;
    logic          w_rd_gnt;
    logic [31:0]   w_ext_data;

    // ------------------------------------------------------------------
    // Arbitration. Everything is gated with rst so that all grants,
    // enables and the stall stay low while reset is asserted, whatever
    // the requesters are doing.
    // ------------------------------------------------------------------
    always_comb begin
        w_starved = (r_starve_cnt == LIMIT);
        w_p1_win  = rst & p1_req & (~p0_req | w_starved);
        w_p0_win  = rst & p0_req & ~w_p1_win;
        w_any_gnt = w_p0_win | w_p1_win;
    end

    assign p0_gnt   = w_p0_win;
    assign p1_gnt   = w_p1_win;
    assign p0_stall = rst & p0_req & ~w_p0_win;

    // ------------------------------------------------------------------
    // Memory-side mux: port 1 only drives the bus when it wins; with no
    // grant the bus idles on port 0's values with both enables low.
    // ------------------------------------------------------------------
    always_comb begin
        if (w_p1_win) begin
            m_addr      = p1_addr;
            m_wdata     = p1_wdata;
            w_sel_we    = p1_we;
            w_sel_func3 = p1_func3;
        end else begin
            m_addr      = p0_addr;
            m_wdata     = p0_wdata;
            w_sel_we    = p0_we;
            w_sel_func3 = p0_func3;
        end
        m_byte_sel = w_sel_func3[1:0];
        m_r_en     = w_any_gnt & ~w_sel_we;
        m_w_en     = w_any_gnt & w_sel_we;
        w_rd_gnt   = m_r_en;
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts port-0 grants while port 1 is waiting,
    // saturating at the limit so port 1 wins on the next contended cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_p1_win || !p1_req) begin
            w_starve_nxt = '0;
        end else if (w_p0_win && r_starve_cnt != LIMIT) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers: starvation counter plus the single outstanding
    // read slot. A new read can be granted while the previous one is
    // returning because the slot is simply overwritten every cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
            r_pend_valid <= 1'b0;
            r_pend_owner <= OWNER_P0;
            r_pend_func3 <= 3'b000;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_pend_valid <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_pend_owner <= w_p1_win ? OWNER_P1 : OWNER_P0;
                r_pend_func3 <= w_sel_func3;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extension of the raw word. Byte/halfword data is taken from
    // the low lanes of the returned word.
    // ------------------------------------------------------------------
    always_comb begin
        w_ext_data = m_rdata;
        case (r_pend_func3)
            F3_LB:   w_ext_data = {{24{m_rdata[7]}}, m_rdata[7:0]};
            F3_LH:   w_ext_data = {{16{m_rdata[15]}}, m_rdata[15:0]};
            F3_LBU:  w_ext_data = {24'h0, m_rdata[7:0]};
            F3_LHU:  w_ext_data = {16'h0, m_rdata[15:0]};
            default: w_ext_data = m_rdata;
        endcase
    end

    // Return steering; data is forced to zero on a port without rvalid.
    always_comb begin
        p0_rvalid = r_pend_valid & (r_pend_owner == OWNER_P0);
        p1_rvalid = r_pend_valid & (r_pend_owner == OWNER_P1);
        p0_rdata  = p0_rvalid ? w_ext_data : 32'h0;
        p1_rdata  = p1_rvalid ? w_ext_data : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter (STARVE_LIMIT = 4). Inputs are driven on
// the falling edge; combinational outputs are sampled 1 ns later and load
// returns one full cycle after the grant. A small word-addressed memory
// model answers m_r_en one cycle later, like the real data RAM.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we;
    logic [31:0] p0_addr, p0_wdata;
    logic [2:0]  p0_func3;
    logic        p0_gnt, p0_stall, p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p1_req, p1_we;
    logic [31:0] p1_addr, p1_wdata;
    logic [2:0]  p1_func3;
    logic        p1_gnt, p1_rvalid;
    logic [31:0] p1_rdata;
    logic [31:0] m_addr, m_wdata;
    logic        m_r_en, m_w_en;
    logic [1:0]  m_byte_sel;
    logic [31:0] m_rdata;

    logic [31:0] mem [0:63];

    int nChecks = 0;
    int nPass   = 0;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_func3(p0_func3), .p0_gnt(p0_gnt), .p0_stall(p0_stall),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_func3(p1_func3), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_r_en(m_r_en), .m_w_en(m_w_en),
        .m_byte_sel(m_byte_sel), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory model.
    always @(posedge clk) begin
        if (m_r_en) m_rdata <= mem[m_addr[7:2]];
    end

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_func3 = 3'b010;
        p1_req = 0; p1_we = 0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_func3 = 3'b010;
    endtask

    // Reset held low with both ports requesting: everything must stay quiet.
    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        p0_req = 1; p0_addr = 32'h10;
        p1_req = 1; p1_addr = 32'h20;
        repeat (2) @(negedge clk);
        #1;
        nChecks++; if (p0_gnt !== 1'b0) $display("[TB] FAIL rst_p0_gnt got %0b exp 0", p0_gnt); else nPass++;
        nChecks++; if (p1_gnt !== 1'b0) $display("[TB] FAIL rst_p1_gnt got %0b exp 0", p1_gnt); else nPass++;
        nChecks++; if (m_r_en !== 1'b0 || m_w_en !== 1'b0) $display("[TB] FAIL rst_men got r=%0b w=%0b exp 0/0", m_r_en, m_w_en); else nPass++;
        nChecks++; if (p0_stall !== 1'b0) $display("[TB] FAIL rst_stall got %0b exp 0", p0_stall); else nPass++;
        nChecks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) $display("[TB] FAIL rst_rvalid got %0b/%0b exp 0/0", p0_rvalid, p1_rvalid); else nPass++;
        nChecks++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) $display("[TB] FAIL rst_rdata got %h/%h exp 0/0", p0_rdata, p1_rdata); else nPass++;
    endtask

    // Release reset with port 0 already requesting LW 0x10: granted at once.
    task automatic test_p0_read();
        idle_inputs();
        p0_req = 1; p0_addr = 32'h10; p0_func3 = 3'b010;
        rst = 1'b1;
        #1;
        nChecks++; if (p0_gnt !== 1'b1) $display("[TB] FAIL rd_p0_gnt got %0b exp 1", p0_gnt); else nPass++;
        nChecks++; if (m_r_en !== 1'b1 || m_w_en !== 1'b0) $display("[TB] FAIL rd_men got r=%0b w=%0b exp 1/0", m_r_en, m_w_en); else nPass++;
        nChecks++; if (m_addr !== 32'h10) $display("[TB] FAIL rd_addr got %h exp 00000010", m_addr); else nPass++;
        nChecks++; if (p0_stall !== 1'b0) $display("[TB] FAIL rd_stall got %0b exp 0", p0_stall); else nPass++;
        @(negedge clk);
        idle_inputs();
        #1;
        nChecks++; if (p0_rvalid !== 1'b1) $display("[TB] FAIL rd_rvalid got %0b exp 1", p0_rvalid); else nPass++;
        nChecks++; if (p0_rdata !== 32'hDEADBEEF) $display("[TB] FAIL rd_rdata got %h exp deadbeef", p0_rdata); else nPass++;
        nChecks++; if (p1_rvalid !== 1'b0 || p1_rdata !== 32'h0) $display("[TB] FAIL rd_p1_quiet got %0b/%h exp 0/0", p1_rvalid, p1_rdata); else nPass++;
        nChecks++; if (m_r_en !== 1'b0) $display("[TB] FAIL rd_cancel_men got %0b exp 0", m_r_en); else nPass++;
        @(negedge clk);
        #1;
        nChecks++; if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) $display("[TB] FAIL rd_once got %0b/%h exp 0/0", p0_rvalid, p0_rdata); else nPass++;
    endtask

    // Both ports reading continuously: p0 x4, then p1 once, then p0 again.
    // Each read's return overlaps the next grant.
    task automatic test_back_to_back();
        idle_inputs();
        p0_req = 1; p0_addr = 32'h10;
        p1_req = 1; p1_addr = 32'h20;
        for (int c = 0; c < 7; c++) begin
            #1;
            nChecks++;
            if (p1_gnt !== (c == 4) || p0_gnt !== (c != 4))
                $display("[TB] FAIL starve_gnt c=%0d got p0=%0b p1=%0b exp p0=%0b p1=%0b", c, p0_gnt, p1_gnt, (c != 4), (c == 4));
            else nPass++;
            nChecks++;
            if (p0_stall !== (c == 4)) $display("[TB] FAIL starve_stall c=%0d got %0b exp %0b", c, p0_stall, (c == 4));
            else nPass++;
            if (c > 0) begin
                nChecks++;
                if (p0_rvalid !== (c != 5) || p1_rvalid !== (c == 5))
                    $display("[TB] FAIL starve_rvalid c=%0d got %0b/%0b exp %0b/%0b", c, p0_rvalid, p1_rvalid, (c != 5), (c == 5));
                else nPass++;
                nChecks++;
                if (c == 5 ? (p1_rdata !== 32'h00008001 || p0_rdata !== 32'h0) : (p0_rdata !== 32'hDEADBEEF || p1_rdata !== 32'h0))
                    $display("[TB] FAIL starve_rdata c=%0d got %h/%h", c, p0_rdata, p1_rdata);
                else nPass++;
            end
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    // Port 1 alone doing sized loads; checks sign/zero extension.
    task automatic p1_load(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] expData, input string name);
        idle_inputs();
        p1_req = 1; p1_addr = addr; p1_func3 = f3;
        #1;
        nChecks++;
        if (p1_gnt !== 1'b1 || m_r_en !== 1'b1 || m_byte_sel !== f3[1:0])
            $display("[TB] FAIL %s_gnt got gnt=%0b ren=%0b sel=%0d exp 1/1/%0d", name, p1_gnt, m_r_en, m_byte_sel, f3[1:0]);
        else nPass++;
        @(negedge clk);
        idle_inputs();
        #1;
        nChecks++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== expData || p0_rvalid !== 1'b0)
            $display("[TB] FAIL %s_data got v=%0b d=%h exp v=1 d=%h", name, p1_rvalid, p1_rdata, expData);
        else nPass++;
        @(negedge clk);
    endtask

    task automatic test_extend();
        p1_load(32'h20, 3'b001, 32'hFFFF8001, "lh");
        p1_load(32'h20, 3'b101, 32'h00008001, "lhu");
        p1_load(32'h24, 3'b000, 32'hFFFFFF80, "lb");
        p1_load(32'h24, 3'b100, 32'h00000080, "lbu");
        p1_load(32'h10, 3'b010, 32'hDEADBEEF, "lw");
    endtask

    // Stores from each port: single-cycle, no return strobe.
    task automatic test_write();
        idle_inputs();
        p0_req = 1; p0_we = 1; p0_addr = 32'h30; p0_wdata = 32'h12345678; p0_func3 = 3'b010;
        #1;
        nChecks++; if (p0_gnt !== 1'b1 || m_w_en !== 1'b1 || m_r_en !== 1'b0) $display("[TB] FAIL sw_en got g=%0b w=%0b r=%0b exp 1/1/0", p0_gnt, m_w_en, m_r_en); else nPass++;
        nChecks++; if (m_wdata !== 32'h12345678 || m_addr !== 32'h30 || m_byte_sel !== 2'b10) $display("[TB] FAIL sw_bus got d=%h a=%h s=%0d exp 12345678/00000030/2", m_wdata, m_addr, m_byte_sel); else nPass++;
        @(negedge clk);
        idle_inputs();
        p1_req = 1; p1_we = 1; p1_addr = 32'h44; p1_wdata = 32'h000000A5; p1_func3 = 3'b000;
        #1;
        nChecks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) $display("[TB] FAIL sw_no_rvalid got %0b/%0b exp 0/0", p0_rvalid, p1_rvalid); else nPass++;
        nChecks++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || m_w_en !== 1'b1) $display("[TB] FAIL sb_p1_en got g1=%0b g0=%0b w=%0b exp 1/0/1", p1_gnt, p0_gnt, m_w_en); else nPass++;
        nChecks++; if (m_addr !== 32'h44 || m_wdata !== 32'hA5 || m_byte_sel !== 2'b00) $display("[TB] FAIL sb_p1_bus got a=%h d=%h s=%0d exp 44/a5/0", m_addr, m_wdata, m_byte_sel); else nPass++;
        @(negedge clk);
        idle_inputs();
        #1;
        nChecks++; if (p1_rvalid !== 1'b0 || p1_rdata !== 32'h0) $display("[TB] FAIL sb_no_rvalid got %0b/%h exp 0/0", p1_rvalid, p1_rdata); else nPass++;
        @(negedge clk);
    endtask

    // Build up starvation count, reset with a read in flight, then confirm
    // the read is lost and the count restarted from zero.
    task automatic test_reset_outstanding();
        idle_inputs();
        p0_req = 1; p0_addr = 32'h10;
        p1_req = 1; p1_addr = 32'h20;
        @(negedge clk);
        #1;
        nChecks++; if (p0_gnt !== 1'b1 || m_r_en !== 1'b1) $display("[TB] FAIL rso_gnt got %0b/%0b exp 1/1", p0_gnt, m_r_en); else nPass++;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        nChecks++; if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) $display("[TB] FAIL rso_in_rst got %0b/%h exp 0/0", p0_rvalid, p0_rdata); else nPass++;
        nChecks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || p0_stall !== 1'b0) $display("[TB] FAIL rso_quiet got %0b/%0b/%0b exp 0/0/0", p0_gnt, p1_gnt, p0_stall); else nPass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        nChecks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) $display("[TB] FAIL rso_discard got %0b/%0b exp 0/0", p0_rvalid, p1_rvalid); else nPass++;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) #1;
            nChecks++;
            if (p1_gnt !== (c == 4) || p0_gnt !== (c != 4))
                $display("[TB] FAIL rso_cnt c=%0d got p0=%0b p1=%0b exp p0=%0b p1=%0b", c, p0_gnt, p1_gnt, (c != 4), (c == 4));
            else nPass++;
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'h00008001;
        mem[9] = 32'h00000080;
        m_rdata = 32'h0;
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_p0_read();
        test_back_to_back();
        test_extend();
        test_write();
        test_reset_outstanding();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL timeout got running exp finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive port-0 grants while port 1 waits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port p0_req  input  1  pipeline MEM-stage access request (priority port).
REQ-005 SHALL have ports p0_we  input  1, p0_addr  input  32, p0_wdata  input  32, p0_func3  input  3  port-0 write flag, address, store data, RISC-V width code.
REQ-006 SHALL have ports p0_gnt  output  1, p0_stall  output  1, p0_rvalid  output  1, p0_rdata  output  32  grant, pipeline hold, load-return strobe, extended load data.
REQ-007 SHALL have ports p1_req, p1_we  input  1; p1_addr, p1_wdata  input  32; p1_func3  input  3  loader/debug requester, same meanings as port 0.
REQ-008 SHALL have ports p1_gnt, p1_rvalid  output  1; p1_rdata  output  32  port-1 grant, return strobe, data.
REQ-009 SHALL have ports m_addr, m_wdata  output  32; m_r_en, m_w_en  output  1; m_byte_sel  output  2  data-memory drive.
REQ-010 SHALL have port m_rdata  input  32  raw memory read word, valid the cycle after m_r_en.

Function
REQ-011 SHALL compute grants combinationally each cycle: p1 wins iff p1_req and (not p0_req or starve_cnt == STARVE_LIMIT); otherwise p0 wins iff p0_req.
REQ-012 SHALL never assert p0_gnt and p1_gnt together.
REQ-013 SHALL drive m_addr/m_wdata/m_byte_sel (func3[1:0]) from the granted port; from port 0 when no grant.
REQ-014 SHALL assert m_r_en = gnt & ~we and m_w_en = gnt & we for the granted port; both 0 with no grant.
REQ-015 SHALL assert p0_stall = p0_req & ~p0_gnt.
REQ-016 starve_cnt (3 bits min) SHALL increment, saturating at STARVE_LIMIT, each cycle p1_req & p0_gnt; SHALL clear on p1_gnt or when p1_req is low.
REQ-017 On a read grant SHALL register pend_valid=1, pend_owner=port, pend_func3=func3; otherwise pend_valid=0 next cycle.
REQ-018 Read latency SHALL be exactly 1 cycle: owner's rvalid=1 the cycle after grant; non-owner rvalid=0.
REQ-019 Return data SHALL be extended per pend_func3: LB sign from bit 7; LH sign from bit 15; LBU/LHU zero-extend byte/halfword; LW and others pass 32 bits.
REQ-020 rdata of a port SHALL be 0 whenever its rvalid is 0.
REQ-021 Writes SHALL complete in the grant cycle; no rvalid for writes.
REQ-022 Back-to-back grants SHALL be allowed every cycle; a new grant may coincide with a previous read's return.
REQ-023 Requesters hold req/we/addr/wdata/func3 stable until granted; arbiter SHALL NOT buffer ungranted requests.
REQ-024 Dropping req before grant SHALL cancel it with no memory access.

Reset
REQ-025 While rst=0: starve_cnt=0, pend_valid=0, pend_owner=0, pend_func3=0.
REQ-026 During reset SHALL hold all grant, enable, stall and rvalid outputs 0 and rdata outputs 0 regardless of inputs.
REQ-027 Reset asserted with a read outstanding SHALL discard it; no rvalid after release.
REQ-028 First grant SHALL be possible in the first clock edge after rst rises.

Verification
REQ-029 p0 LW addr 0x10 (mem 0xDEADBEEF), p1 idle -> p0_gnt=1, m_r_en=1; next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF.
REQ-030 Both requesting continuously, STARVE_LIMIT=4 -> p0 granted cycles 0-3, p1 granted cycle 4 with p0_stall=1, p0 resumes cycle 5.
REQ-031 p1 LH returning 0x00008001 -> p1_rdata=0xFFFF8001; LHU -> 0x00008001; LB of 0x00000080 -> 0xFFFFFF80.
REQ-032 p0 SW data 0x12345678 while p1_req low -> m_w_en=1, m_wdata=0x12345678, no rvalid next cycle.
REQ-033 p0 read granted, rst low before next edge -> p0_rvalid stays 0, starve_cnt=0 after release.
